hilo_div_ctrl: RTL

//  Sequences the shared 32-bit unsigned iterative divider for MIPS DIV/DIVU and owns the HI/LO registers.

---
 rtl/hilo_div_if.sv | 19 +
 rtl/hilo_div_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/hilo_div_if.sv
// Handshake/data bus between the HI/LO divide controller and the shared iterative divider.
interface hilo_div_if;
    logic        dv_in_valid;
    logic [31:0] dv_dividend;
    logic [31:0] dv_divisor;
    logic [31:0] dv_quotient;
    logic [31:0] dv_remainder;
    logic        dv_out_valid;

    modport master (
        output dv_in_valid, dv_dividend, dv_divisor,
        input  dv_quotient, dv_remainder, dv_out_valid
    );

    modport slave (
        input  dv_in_valid, dv_dividend, dv_divisor,
        output dv_quotient, dv_remainder, dv_out_valid
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequences the shared unsigned divider for DIV/DIVU in the background and owns HI/LO.
// state   | meaning
// S_IDLE  | HI/LO accessible; accepts DIV/DIVU, MTHI/MTLO
// S_ISSUE | one-cycle start pulse to the divider, watchdog loaded
// S_WAIT  | waiting for divider result, watchdog counting down
// S_FIX   | apply result signs and write HI/LO
module hilo_div_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        mfhi_req,
    input  logic        mflo_req,
    input  logic        mthi_req,
    input  logic        mtlo_req,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        busy,
    output logic        dz_flag,
    output logic        err_timeout,
    hilo_div_if.master  dv
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIX   = 2'd3;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [CW-1:0] wd_cnt;
    logic          neg_q;
    logic          neg_r;
    logic [31:0]   dividend_r;
    logic [31:0]   divisor_r;
    logic [31:0]   q_r;
    logic [31:0]   r_r;

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    assign busy           = (state != S_IDLE);
    assign stall          = busy & (div_req | mfhi_req | mflo_req | mthi_req | mtlo_req);
    assign dv.dv_in_valid = (state == S_ISSUE);
    assign dv.dv_dividend = dividend_r;
    assign dv.dv_divisor  = divisor_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wd_cnt      <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dividend_r  <= '0;
            divisor_r   <= '0;
            q_r         <= '0;
            r_r         <= '0;
            hi          <= '0;
            lo          <= '0;
            dz_flag     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A divide wins over a same-cycle MTHI/MTLO, which is dropped.
                    if (div_req) begin
                        if (div_b == 32'd0) begin
                            hi      <= div_a;
                            lo      <= 32'hFFFF_FFFF;
                            dz_flag <= 1'b1;
                        end else begin
                            neg_q      <= div_signed & (div_a[31] ^ div_b[31]);
                            neg_r      <= div_signed & div_a[31];
                            dividend_r <= mag(div_a, div_signed);
                            divisor_r  <= mag(div_b, div_signed);
                            dz_flag    <= 1'b0;
                            state      <= S_ISSUE;
                        end
                    end else begin
                        if (mthi_req) hi <= mt_data;
                        if (mtlo_req) lo <= mt_data;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= CW'(TIMEOUT - 1);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (dv.dv_out_valid) begin
                        q_r   <= dv.dv_quotient;
                        r_r   <= dv.dv_remainder;
                        state <= S_FIX;
                    end else if (wd_cnt == '0) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    lo    <= neg_q ? (~q_r + 32'd1) : q_r;
                    hi    <= neg_r ? (~r_r + 32'd1) : r_r;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
